chdr_ctrl_frame_guard: RTL and testbench
========================================

Name: chdr_ctrl_frame_guard

Overview:
- Cut-through CHDR framing guard on the host control stream, directly upstream of the core's ctrl input and its SID demux.
- Guarantees every packet it emits has exactly ceil(len/8) beats, where len is the header length field, so that the demux, control processor and radio never see a runt, overlong or stalled packet.
- Pads short packets, truncates long ones, drops packets with an illegal length, and closes packets that stall mid-stream.
- Keeps saturating error counters for host readback.

Parameters:
- MAX_BYTES, 16'd512: largest legal header length field in bytes; a header with a larger value drops the whole packet.
- TIMEOUT, 16: consecutive idle cycles inside a packet before the packet is force-closed; 0 disables the timeout.
- CNT_W, 16: width of each error counter.

Ports:
- clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous; zeroes the counters and aborts the current packet gracefully
- i_tdata  in  64  CHDR input; on the header beat, [47:32] is the length in bytes
- i_tlast  in  1  input end of packet
- i_tvalid  in  1  input valid
- i_tready  out  1  input ready
- o_tdata  out  64  guarded CHDR output
- o_tlast  out  1  output end of packet
- o_tvalid  out  1  output valid
- o_tready  in  1  output ready
- cnt_short  out  CNT_W  packets padded (early tlast)
- cnt_long  out  CNT_W  packets truncated (late tlast)
- cnt_drop  out  CNT_W  packets dropped (illegal length)
- cnt_timeout  out  CNT_W  packets closed by timeout
- busy  out  1  state other than IDLE

Behaviour:
- Reset (reset_n low, async): state=IDLE; o_tvalid=0, o_tdata=0, o_tlast=0; all counters 0; busy=0; beat counter 0; in_open=0; idle counter 0.
- Output stage: one registered stage.
  - i_tready = (state in IDLE/BODY/DROP) && (!o_tvalid || o_tready). In PAD, i_tready=0.
  - Latency is 1 cycle from an accepted input beat to o_tvalid. Full throughput, no bubbles.
  - o_tdata/o_tlast are held stable while o_tvalid && !o_tready.
- Beat count: exp = (len+7)>>3, 13 bits.
- Illegal length: len<8 or len>MAX_BYTES.
- IDLE, on an accepted header beat:
  - Illegal length: nothing is emitted; cnt_drop++; go DROP (or stay IDLE if this beat has i_tlast).
  - Else emit the beat with o_tlast=(exp==1).
    - exp==1 && i_tlast: stay IDLE.
    - exp==1 && !i_tlast: emit with tlast forced; cnt_long++; go DROP.
    - exp>1 && i_tlast: cnt_short++; go PAD.
    - exp>1 && !i_tlast: go BODY with beats remaining = exp-1.
- BODY, on an accepted beat (remaining decrements):
  - remaining==1: emit with o_tlast=1.
    - i_tlast set: go IDLE.
    - i_tlast clear: cnt_long++; go DROP.
  - remaining>1 && i_tlast: emit with o_tlast=0; cnt_short++; in_open=0; go PAD.
  - Otherwise emit the beat and stay in BODY.
- PAD:
  - Emits 64'h0 beats, one per output slot, until remaining reaches 0; the last pad beat carries o_tlast=1.
  - On completion, go DROP if in_open, else IDLE.
- DROP:
  - i_tready=1 (subject to the output-stage rule); beats are discarded.
  - Go IDLE on an accepted i_tlast.
- Timeout:
  - Active in BODY only. The idle counter increments on each cycle with !i_tvalid and resets on each accepted beat.
  - When it reaches TIMEOUT: cnt_timeout++; in_open=1; go PAD.
  - Downstream backpressure (i_tvalid high but not accepted) does not count toward the timeout.
- clear:
  - Zeroes the counters in the same cycle and has priority over any increment in that cycle.
  - In BODY: go PAD with in_open=1.
  - In IDLE, PAD or DROP: no state change.
- Counters saturate at all-ones.
- Simultaneous events: an accepted beat in the same cycle as the timeout threshold counts as activity, so the timeout does not fire.

Decomposition:
- Shared package chdr_pkg holds:
  - CHDR_LEN_HI=47 and CHDR_LEN_LO=32
  - the state enum {IDLE, BODY, PAD, DROP}
  - a function chdr_beats(len)
- Natural sub-module: chdr_out_reg, a single-stage valid/ready output register with the async active-low reset. The FSM and counters stay in the top level.

Test Plan:
- Legal packet, len=24, 3 beats, tlast on beat 3, o_tready=1 -> 3 beats out unchanged, tlast on beat 3, all counters 0, 1-cycle latency.
- Short packet, len=32, tlast on beat 2 -> 2 data beats, then 2 zero beats with tlast on beat 4; cnt_short=1.
- Long packet, len=16, 5 input beats -> 2 beats out with tlast forced on beat 2; 3 beats dropped; cnt_long=1; the next packet passes intact.
- Illegal lengths, len=4 and then len=MAX_BYTES+8 -> no output for either; cnt_drop=2; i_tready stays high through both.
- Timeout, TIMEOUT=16, len=40: 2 beats then i_tvalid low for 16 cycles -> 3 zero pad beats with tlast on the 5th output beat; cnt_timeout=1; the late remainder of the packet is discarded up to its tlast.
- Backpressure and reset: random o_tready with 30% stalls -> output data stable while stalled and no beat lost. Then reset_n asserted mid-BODY -> o_tvalid=0 immediately (asynchronously), counters 0, and the next header is handled from IDLE.

Source files
------------

// File: rtl/chdr_pkg.sv
// ---------------------------------------------------------------------------
// chdr_pkg
//   Shared definitions for the CHDR control-stream framing guard.
//   - CHDR_LEN_HI / CHDR_LEN_LO : bit range of the byte-length field in the
//     64-bit header beat
//   - guard_state_t             : framing guard state machine encoding
//   - chdr_beats()              : converts a byte length into a 64-bit beat count
// ---------------------------------------------------------------------------
package chdr_pkg;

    localparam int CHDR_LEN_HI = 47;
    localparam int CHDR_LEN_LO = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BODY = 2'd1,
        PAD  = 2'd2,
        DROP = 2'd3
    } guard_state_t;

    // ceil(len/8), kept to 13 bits. The 17-bit intermediate avoids wrapping the
    // +7 for lengths near 16'hFFFF. Those lengths are always illegal, so losing
    // the top bit of the quotient is harmless.
    function automatic logic [12:0] chdr_beats(input logic [15:0] len);
        logic [16:0] sum;
        sum = {1'b0, len} + 17'd7;
        return sum[15:3];
    endfunction

endpackage

// File: rtl/chdr_out_reg.sv
// ---------------------------------------------------------------------------
// chdr_out_reg
//   Single-stage valid/ready output register. It can take a new beat
//   whenever it is empty or its current beat is being consumed, so a
//   continuously ready sink sees full throughput.
//   Ports:
//     clk, reset_n        clock, asynchronous active-low reset
//     s_valid/s_data/s_last  beat offered by the guard logic
//     s_ready             register can load this cycle
//     m_valid/m_data/m_last  registered output beat
//     m_ready             downstream ready
// ---------------------------------------------------------------------------
module chdr_out_reg #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         s_valid,
    input  logic [W-1:0] s_data,
    input  logic         s_last,
    output logic         s_ready,
    output logic         m_valid,
    output logic [W-1:0] m_data,
    output logic         m_last,
    input  logic         m_ready
);

    assign s_ready = !m_valid || m_ready;

    // Data and last only move on a real load, so they stay put while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (s_ready) begin
            m_valid <= s_valid;
            if (s_valid) begin
                m_data <= s_data;
                m_last <= s_last;
            end
        end
    end

endmodule

// File: rtl/chdr_ctrl_frame_guard.sv
// ---------------------------------------------------------------------------
// chdr_ctrl_frame_guard
//   Cut-through framing guard for the host CHDR control stream. Every packet
//   leaving this block has exactly ceil(len/8) beats:
//   - short packets are padded with zero beats
//   - long packets are truncated, and the excess is dropped
//   - packets with an illegal length are dropped whole
//   - packets that stall inside the body are padded out
//   Saturating error counters are kept for host readback.
//   Ports:
//     clk, reset_n                  clock, asynchronous active-low reset
//     clear                         zero counters, abort current packet
//     i_tdata/i_tlast/i_tvalid/i_tready  input CHDR stream
//     o_tdata/o_tlast/o_tvalid/o_tready  guarded CHDR stream
//     cnt_short/cnt_long/cnt_drop/cnt_timeout  error counters
//     busy                          state is not IDLE
// ---------------------------------------------------------------------------
module chdr_ctrl_frame_guard
    import chdr_pkg::*;
#(
    parameter logic [15:0] MAX_BYTES = 16'd512,
    parameter int          TIMEOUT   = 16,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [63:0]      i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [63:0]      o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic [CNT_W-1:0] cnt_short,
    output logic [CNT_W-1:0] cnt_long,
    output logic [CNT_W-1:0] cnt_drop,
    output logic [CNT_W-1:0] cnt_timeout,
    output logic             busy
);

    localparam bit          TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

    guard_state_t state, state_next;
    logic [12:0]  remaining, remaining_next;
    logic         in_open, in_open_next;
    logic [15:0]  idle_cnt, idle_cnt_next;
    logic         inc_short, inc_long, inc_drop, inc_timeout;

    logic         can_load;
    logic         accept;
    logic [15:0]  hdr_len;
    logic [12:0]  exp_beats;
    logic         len_bad;
    logic         emit_valid;
    logic [63:0]  emit_data;
    logic         emit_last;

    assign hdr_len   = i_tdata[CHDR_LEN_HI:CHDR_LEN_LO];
    assign exp_beats = chdr_beats(hdr_len);
    assign len_bad   = (hdr_len < 16'd8) || (hdr_len > MAX_BYTES);
    assign i_tready  = (state != PAD) && can_load;
    assign accept    = i_tvalid && i_tready;
    assign busy      = (state != IDLE);

    // State register plus the per-packet bookkeeping that moves with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            remaining <= '0;
            in_open   <= 1'b0;
            idle_cnt  <= '0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            in_open   <= in_open_next;
            idle_cnt  <= idle_cnt_next;
        end
    end

    // Next-state logic. remaining counts output beats still owed for the packet.
    // in_open marks that the input packet has not yet delivered its tlast, so
    // after padding its tail must be swallowed in DROP.
    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        in_open_next   = in_open;
        idle_cnt_next  = idle_cnt;
        inc_short      = 1'b0;
        inc_long       = 1'b0;
        inc_drop       = 1'b0;
        inc_timeout    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (len_bad) begin
                        inc_drop = 1'b1;
                        if (!i_tlast) state_next = DROP;
                    end else if (exp_beats == 13'd1) begin
                        if (!i_tlast) begin
                            inc_long   = 1'b1;
                            state_next = DROP;
                        end
                    end else begin
                        remaining_next = exp_beats - 13'd1;
                        idle_cnt_next  = '0;
                        if (i_tlast) begin
                            inc_short    = 1'b1;
                            in_open_next = 1'b0;
                            state_next   = PAD;
                        end else begin
                            state_next = BODY;
                        end
                    end
                end
            end
            BODY: begin
                // On clear, any beat accepted this cycle is discarded unsent.
                // remaining is left alone so the padding still completes the
                // packet.
                if (clear) begin
                    state_next   = PAD;
                    in_open_next = !(accept && i_tlast);
                end else if (accept) begin
                    idle_cnt_next  = '0;
                    remaining_next = remaining - 13'd1;
                    if (remaining == 13'd1) begin
                        if (i_tlast) begin
                            state_next = IDLE;
                        end else begin
                            inc_long   = 1'b1;
                            state_next = DROP;
                        end
                    end else if (i_tlast) begin
                        inc_short    = 1'b1;
                        in_open_next = 1'b0;
                        state_next   = PAD;
                    end
                end else if (!i_tvalid && TIMEOUT_EN) begin
                    if (idle_cnt == TIMEOUT_M1) begin
                        inc_timeout   = 1'b1;
                        in_open_next  = 1'b1;
                        idle_cnt_next = '0;
                        state_next    = PAD;
                    end else begin
                        idle_cnt_next = idle_cnt + 16'd1;
                    end
                end
            end
            PAD: begin
                if (can_load) begin
                    remaining_next = remaining - 13'd1;
                    if (remaining == 13'd1) state_next = in_open ? DROP : IDLE;
                end
            end
            DROP: begin
                if (accept && i_tlast) state_next = IDLE;
            end
            default: ;
        endcase
    end

    // Output logic: decides which beat, if any, is offered to the output register.
    always_comb begin
        emit_valid = 1'b0;
        emit_data  = '0;
        emit_last  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept && !len_bad) begin
                    emit_valid = 1'b1;
                    emit_data  = i_tdata;
                    emit_last  = (exp_beats == 13'd1);
                end
            end
            BODY: begin
                if (accept && !clear) begin
                    emit_valid = 1'b1;
                    emit_data  = i_tdata;
                    emit_last  = (remaining == 13'd1);
                end
            end
            PAD: begin
                if (can_load) begin
                    emit_valid = 1'b1;
                    emit_last  = (remaining == 13'd1);
                end
            end
            default: ;
        endcase
    end

    // Saturating error counters. clear wins over any increment in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_short   <= '0;
            cnt_long    <= '0;
            cnt_drop    <= '0;
            cnt_timeout <= '0;
        end else if (clear) begin
            cnt_short   <= '0;
            cnt_long    <= '0;
            cnt_drop    <= '0;
            cnt_timeout <= '0;
        end else begin
            if (inc_short   && (cnt_short   != '1)) cnt_short   <= cnt_short   + CNT_W'(1);
            if (inc_long    && (cnt_long    != '1)) cnt_long    <= cnt_long    + CNT_W'(1);
            if (inc_drop    && (cnt_drop    != '1)) cnt_drop    <= cnt_drop    + CNT_W'(1);
            if (inc_timeout && (cnt_timeout != '1)) cnt_timeout <= cnt_timeout + CNT_W'(1);
        end
    end

    chdr_out_reg #(.W(64)) u_out_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .s_valid (emit_valid),
        .s_data  (emit_data),
        .s_last  (emit_last),
        .s_ready (can_load),
        .m_valid (o_tvalid),
        .m_data  (o_tdata),
        .m_last  (o_tlast),
        .m_ready (o_tready)
    );

endmodule

// File: tb/tb_chdr_ctrl_frame_guard.sv
// ---------------------------------------------------------------------------
// tb_chdr_ctrl_frame_guard
//   Directed bench for the CHDR control framing guard. Output beats are
//   collected by a monitor and compared against hand-written expected
//   packets. Counters and handshake signals are checked at key points.
// ---------------------------------------------------------------------------
module tb_chdr_ctrl_frame_guard;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear;
    logic [63:0] i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        i_tready;
    logic [63:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready = 1'b1;
    logic [15:0] cnt_short, cnt_long, cnt_drop, cnt_timeout;
    logic        busy;

    int          errors = 0;
    int          checks = 0;
    bit          rand_ready = 1'b0;

    logic [63:0] got_d[$];
    logic        got_l[$];
    logic [63:0] exp_d[$];
    logic        exp_l[$];

    bit          hold_pending = 1'b0;
    logic [63:0] held_data;
    logic        held_last;

    chdr_ctrl_frame_guard #(
        .MAX_BYTES (16'd512),
        .TIMEOUT   (16),
        .CNT_W     (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .i_tdata     (i_tdata),
        .i_tlast     (i_tlast),
        .i_tvalid    (i_tvalid),
        .i_tready    (i_tready),
        .o_tdata     (o_tdata),
        .o_tlast     (o_tlast),
        .o_tvalid    (o_tvalid),
        .o_tready    (o_tready),
        .cnt_short   (cnt_short),
        .cnt_long    (cnt_long),
        .cnt_drop    (cnt_drop),
        .cnt_timeout (cnt_timeout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Sink ready: constant high, or high about 70% of the time in backpressure mode.
    always @(posedge clk) begin
        #1;
        if (rand_ready) o_tready = ($urandom_range(0, 99) >= 30);
        else            o_tready = 1'b1;
    end

    function automatic logic [63:0] mkHdr(input logic [15:0] len);
        return {16'hA5A5, len, 16'h0000, len};
    endfunction

    function automatic logic [63:0] mkData(input int pkt, input int beat);
        return {32'hDA7A_0000, 16'(pkt), 16'(beat)};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one input beat and wait (bounded) for it to be accepted.
    // The task is entered and left 1 ns after a rising edge.
    task automatic applyStimulus(input logic [63:0] data, input logic last);
        bit accepted;
        accepted = 1'b0;
        i_tdata  = data;
        i_tlast  = last;
        i_tvalid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (i_tready) begin
                accepted = 1'b1;
                break;
            end
        end
        checkOutput("input_accept", 64'(accepted), 64'd1);
        @(posedge clk);
        #1;
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkCounters(input string tag, input int s, input int l,
                                 input int d, input int t);
        checkOutput({tag, "_cnt_short"},   64'(cnt_short),   64'(s));
        checkOutput({tag, "_cnt_long"},    64'(cnt_long),    64'(l));
        checkOutput({tag, "_cnt_drop"},    64'(cnt_drop),    64'(d));
        checkOutput({tag, "_cnt_timeout"}, 64'(cnt_timeout), 64'(t));
    endtask

    task automatic checkBeats(input string tag);
        checkOutput({tag, "_beat_count"}, 64'(got_d.size()), 64'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            checkOutput($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
            checkOutput($sformatf("%s_last%0d", tag, i), 64'(got_l[i]), 64'(exp_l[i]));
        end
        got_d.delete();
        got_l.delete();
    endtask

    // Output monitor. The bench only changes inputs just after a rising edge,
    // so values seen at the falling edge are what the next rising edge samples.
    always @(negedge clk) begin
        if (!reset_n) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                checkOutput("hold_valid", 64'(o_tvalid), 64'd1);
                checkOutput("hold_data",  o_tdata,       held_data);
                checkOutput("hold_last",  64'(o_tlast),  64'(held_last));
            end
            if (o_tvalid && o_tready) begin
                got_d.push_back(o_tdata);
                got_l.push_back(o_tlast);
            end
            hold_pending = o_tvalid && !o_tready;
            held_data    = o_tdata;
            held_last    = o_tlast;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n  = 1'b0;
        clear    = 1'b0;
        i_tdata  = '0;
        i_tlast  = 1'b0;
        i_tvalid = 1'b0;
        waitCycles(3);

        // Reset state
        checkOutput("rst_o_tvalid", 64'(o_tvalid), 64'd0);
        checkOutput("rst_o_tdata",  o_tdata,       64'd0);
        checkOutput("rst_o_tlast",  64'(o_tlast),  64'd0);
        checkOutput("rst_busy",     64'(busy),     64'd0);
        checkCounters("rst", 0, 0, 0, 0);
        reset_n = 1'b1;
        waitCycles(2);
        checkOutput("idle_i_tready", 64'(i_tready), 64'd1);

        // Legal packet, len=24, 3 beats, header appears one cycle after acceptance
        applyStimulus(mkHdr(16'd24), 1'b0);
        checkOutput("legal_latency_valid", 64'(o_tvalid), 64'd1);
        checkOutput("legal_latency_data",  o_tdata,       mkHdr(16'd24));
        applyStimulus(mkData(1, 1), 1'b0);
        applyStimulus(mkData(1, 2), 1'b1);
        waitCycles(4);
        exp_d = '{mkHdr(16'd24), mkData(1, 1), mkData(1, 2)};
        exp_l = '{1'b0, 1'b0, 1'b1};
        checkBeats("legal");
        checkCounters("legal", 0, 0, 0, 0);
        checkOutput("legal_busy", 64'(busy), 64'd0);

        // Short packet, len=32, tlast on beat 2, padded with two zero beats
        applyStimulus(mkHdr(16'd32), 1'b0);
        applyStimulus(mkData(2, 1), 1'b1);
        checkOutput("short_pad_i_tready", 64'(i_tready), 64'd0);
        checkOutput("short_pad_busy",     64'(busy),     64'd1);
        waitCycles(6);
        exp_d = '{mkHdr(16'd32), mkData(2, 1), 64'd0, 64'd0};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
        checkBeats("short");
        checkCounters("short", 1, 0, 0, 0);

        // Long packet, len=16 with 5 beats, truncated at beat 2; next packet intact
        applyStimulus(mkHdr(16'd16), 1'b0);
        for (int b = 1; b <= 4; b++) applyStimulus(mkData(3, b), (b == 4));
        applyStimulus(mkHdr(16'd8), 1'b1);
        waitCycles(4);
        exp_d = '{mkHdr(16'd16), mkData(3, 1), mkHdr(16'd8)};
        exp_l = '{1'b0, 1'b1, 1'b1};
        checkBeats("long");
        checkCounters("long", 1, 1, 0, 0);

        // Illegal lengths: below 8 bytes and above MAX_BYTES, both dropped whole
        applyStimulus(mkHdr(16'd4), 1'b0);
        checkOutput("drop1_i_tready", 64'(i_tready), 64'd1);
        checkOutput("drop1_busy",     64'(busy),     64'd1);
        applyStimulus(mkData(4, 1), 1'b1);
        checkOutput("drop1_end_i_tready", 64'(i_tready), 64'd1);
        applyStimulus(mkHdr(16'd520), 1'b0);
        checkOutput("drop2_i_tready", 64'(i_tready), 64'd1);
        applyStimulus(mkData(5, 1), 1'b1);
        checkOutput("drop2_end_i_tready", 64'(i_tready), 64'd1);
        waitCycles(4);
        exp_d.delete();
        exp_l.delete();
        checkBeats("illegal");
        checkCounters("illegal", 1, 1, 2, 0);
        checkOutput("illegal_busy", 64'(busy), 64'd0);

        // Timeout, len=40: 2 beats then 16 idle cycles, 3 pad beats, tail dropped
        applyStimulus(mkHdr(16'd40), 1'b0);
        applyStimulus(mkData(6, 1), 1'b0);
        waitCycles(15);
        checkOutput("timeout_not_yet_i_tready", 64'(i_tready), 64'd1);
        waitCycles(1);
        checkOutput("timeout_fired_i_tready", 64'(i_tready), 64'd0);
        for (int b = 2; b <= 4; b++) applyStimulus(mkData(6, b), (b == 4));
        waitCycles(4);
        exp_d = '{mkHdr(16'd40), mkData(6, 1), 64'd0, 64'd0, 64'd0};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        checkBeats("timeout");
        checkCounters("timeout", 1, 1, 2, 1);
        checkOutput("timeout_busy", 64'(busy), 64'd0);

        // Clear in BODY zeroes counters and pads out the packet, then drops its tail
        applyStimulus(mkHdr(16'd40), 1'b0);
        applyStimulus(mkData(7, 1), 1'b0);
        clear = 1'b1;
        waitCycles(1);
        clear = 1'b0;
        checkCounters("clear", 0, 0, 0, 0);
        checkOutput("clear_i_tready", 64'(i_tready), 64'd0);
        for (int b = 2; b <= 4; b++) applyStimulus(mkData(7, b), (b == 4));
        waitCycles(4);
        exp_d = '{mkHdr(16'd40), mkData(7, 1), 64'd0, 64'd0, 64'd0};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        checkBeats("clear");
        checkOutput("clear_busy", 64'(busy), 64'd0);

        // Backpressure: random sink stalls, nothing lost, held beats stable
        rand_ready = 1'b1;
        applyStimulus(mkHdr(16'd24), 1'b0);
        applyStimulus(mkData(8, 1), 1'b0);
        applyStimulus(mkData(8, 2), 1'b1);
        applyStimulus(mkHdr(16'd32), 1'b0);
        applyStimulus(mkData(9, 1), 1'b1);
        applyStimulus(mkHdr(16'd16), 1'b0);
        applyStimulus(mkData(10, 1), 1'b1);
        waitCycles(60);
        rand_ready = 1'b0;
        waitCycles(4);
        exp_d = '{mkHdr(16'd24), mkData(8, 1), mkData(8, 2),
                  mkHdr(16'd32), mkData(9, 1), 64'd0, 64'd0,
                  mkHdr(16'd16), mkData(10, 1)};
        exp_l = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        checkBeats("backpressure");
        checkCounters("backpressure", 1, 0, 0, 0);

        // Asynchronous reset mid-BODY, then a fresh header from IDLE
        applyStimulus(mkHdr(16'd40), 1'b0);
        applyStimulus(mkData(11, 1), 1'b0);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_o_tvalid", 64'(o_tvalid), 64'd0);
        checkOutput("async_rst_o_tdata",  o_tdata,       64'd0);
        checkOutput("async_rst_busy",     64'(busy),     64'd0);
        checkCounters("async_rst", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        waitCycles(2);
        got_d.delete();
        got_l.delete();
        applyStimulus(mkHdr(16'd8), 1'b1);
        waitCycles(4);
        exp_d = '{mkHdr(16'd8)};
        exp_l = '{1'b1};
        checkBeats("after_reset");
        checkOutput("after_reset_busy", 64'(busy), 64'd0);
        checkCounters("after_reset", 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
